tile_console: RTL and testbench
===============================

// Module: tile_console
// PURPOSE
//  Write-side controller for the character tile RAM. Accepts a byte stream of character codes on a
//  valid/ready handshake, keeps a text cursor, and drives the RAM write port (wclk = clk).
//  Handles control codes and clears the screen after reset; the read/scan-out side is untouched.
// PARAMETERS
//  ZOOM    0    tile size 8<<ZOOM px; COLS = 80>>ZOOM, ROWS = 60>>ZOOM
//  STRIDE  80   RAM row stride in cells; fixed at 80 regardless of ZOOM, matching the read side
//  AW      13   RAM address width
// PORTS
//  clk        in   1           system clock
//  rst        in   1           asynchronous, active-high reset
//  char_i     in   FONT_WIDTH  character code to print or control code
//  valid_i    in   1           char_i valid
//  ready_o    out  1           block can accept; transfer happens when valid_i && ready_o
//  wen_o      out  1           RAM write enable (drives write_en)
//  waddr_o    out  AW          RAM write address = y*STRIDE + x
//  wdata_o    out  FONT_WIDTH  RAM write data
//  cur_x_o    out  7           cursor column, 0..COLS-1
//  cur_y_o    out  6           cursor row, 0..ROWS-1
//  busy_o     out  1           a clear sweep (screen or row) is in progress
// BEHAVIOUR
//  Reset values: wen_o=0, waddr_o=0, wdata_o=0, cur_x_o=0, cur_y_o=0, ready_o=0, busy_o=1, state=CLR_SCR.
//  ready_o is combinational and equals (state==IDLE). All other outputs are registered.
//  States and transitions:
//  - CLR_SCR: write BLANK (8'h20) to every cell in row-major order, one per cycle, COLS*ROWS cycles.
//    Then set the cursor to (0,0) and go to IDLE.
//  - IDLE: on a transfer, decode char_i:
//    * printable (>= 8'h20): next cycle wen_o=1, addr(x,y), data=char_i. Then x++.
//      If x becomes COLS: x=0, y=(y+1) mod ROWS, go to CLR_ROW.
//    * LF 8'h0A: x=0, y=(y+1) mod ROWS, go to CLR_ROW. No write for the LF itself.
//    * CR 8'h0D: x=0. No write.
//    * BS 8'h08: if x>0, x-- and write BLANK at the new x next cycle. If x==0, no-op.
//    * FF 8'h0C: go to CLR_SCR. The cursor homes when the sweep ends.
//    * any other code < 8'h20: ignored; consumed with no write.
//  - CLR_ROW: write BLANK to cells (0..COLS-1, y), COLS cycles, then IDLE. Wrapping to row 0 reuses
//    the screen; there is no scroll.
//  Latency: wen_o asserts exactly 1 cycle after the accepting edge. Throughput is 1 printable per
//  cycle until a wrap.
//  During clear states ready_o=0 and valid_i is ignored. The producer holds char_i until accepted.
//  busy_o=1 in CLR_SCR and CLR_ROW. wen_o=1 on every sweep cycle.
//  Address arithmetic is unsigned. y*STRIDE is computed at AW bits; the maximum address is 4799 < 2^13.
//  Wrap boundaries: printable at x=COLS-1, y=ROWS-1 writes that cell, then moves to (0,0) and clears row 0.
//  Mid-operation rst: all outputs return to reset values asynchronously. After release, a full CLR_SCR restarts.
// STRUCTURE
//  const.vh gets: CH_BLANK, CH_LF, CH_CR, CH_BS, CH_FF, and the state encodings TC_IDLE, TC_CLR_SCR, TC_CLR_ROW.
//  Sub-module tile_sweep (x/y counter with a start input, a row-only mode and a done pulse) drives both
//  clear states.
//  The address multiply uses the same y*STRIDE + x form as the read path.
// TESTING
//  1 rst pulse, ZOOM=0 -> ready_o low for 4800 cycles, 4800 BLANK writes at addr 0..4799 (stride 80),
//    then ready_o=1 at (0,0).
//  2 send "AB" back-to-back -> writes (0,'A') then (1,'B') on consecutive cycles; cursor (2,0).
//  3 80 printables on row 0 -> the last write is at addr 79, cursor (0,1), then 80 BLANK writes at
//    addr 80..159 with ready_o=0.
//  4 cursor (0,59) + LF -> cursor (0,0), CLR_ROW writes addr 0..79.
//  5 "X", BS, BS -> BLANK written at addr 0, cursor (0,0); the second BS does nothing.
//  6 FF in the middle of a line, and rst asserted in the middle of a CLR_ROW -> full-screen sweep,
//    then cursor (0,0). Outputs go to reset values immediately on rst.

Source files
------------

// File: rtl/tile_console_pkg.sv
// Shared constants and state encoding for the character tile write controller.
package tile_console_pkg;

    localparam logic [7:0] CH_BLANK = 8'h20;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;

    typedef enum logic [1:0] {
        TC_IDLE    = 2'd0,
        TC_CLR_SCR = 2'd1,
        TC_CLR_ROW = 2'd2
    } tc_state_e;

endpackage

// File: rtl/tile_sweep.sv
// Row-major cell walker used for both full-screen and single-row clears.
module tile_sweep #(
    parameter int COLS = 80,
    parameter int ROWS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       row_mode_i,
    input  logic [5:0] row_i,
    output logic [6:0] x_o,
    output logic [5:0] y_o,
    output logic       done_o
);

    logic       active_q, active_d;
    logic       row_mode_q, row_mode_d;
    logic [6:0] x_q, x_d;
    logic [5:0] y_q, y_d;
    logic       last;

    // Comes out of reset already walking the whole screen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q   <= 1'b1;
            row_mode_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            active_q   <= active_d;
            row_mode_q <= row_mode_d;
            x_q        <= x_d;
            y_q        <= y_d;
        end
    end

    assign last = active_q && (x_q == 7'(COLS - 1))
                && (row_mode_q || (y_q == 6'(ROWS - 1)));

    always_comb begin
        active_d   = active_q;
        row_mode_d = row_mode_q;
        x_d        = x_q;
        y_d        = y_q;
        if (start_i) begin
            active_d   = 1'b1;
            row_mode_d = row_mode_i;
            x_d        = '0;
            y_d        = row_mode_i ? row_i : 6'd0;
        end else if (active_q) begin
            if (last) begin
                active_d = 1'b0;
                x_d      = '0;
            end else if (x_q == 7'(COLS - 1)) begin
                x_d = '0;
                y_d = y_q + 6'd1;
            end else begin
                x_d = x_q + 7'd1;
            end
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign done_o = last;

endmodule

// File: rtl/tile_console.sv
// Write-side controller for the character tile RAM: byte stream in,
// cursor tracking, control codes and clear sweeps out to the write port.
module tile_console
    import tile_console_pkg::*;
#(
    parameter int ZOOM       = 0,
    parameter int STRIDE     = 80,
    parameter int AW         = 13,
    parameter int FONT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FONT_WIDTH-1:0] char_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  wen_o,
    output logic [AW-1:0]         waddr_o,
    output logic [FONT_WIDTH-1:0] wdata_o,
    output logic [6:0]            cur_x_o,
    output logic [5:0]            cur_y_o,
    output logic                  busy_o
);

    localparam int COLS = 80 >> ZOOM;
    localparam int ROWS = 60 >> ZOOM;

    localparam logic [FONT_WIDTH-1:0] BLANK_W = FONT_WIDTH'(CH_BLANK);
    localparam logic [FONT_WIDTH-1:0] LF_W    = FONT_WIDTH'(CH_LF);
    localparam logic [FONT_WIDTH-1:0] CR_W    = FONT_WIDTH'(CH_CR);
    localparam logic [FONT_WIDTH-1:0] BS_W    = FONT_WIDTH'(CH_BS);
    localparam logic [FONT_WIDTH-1:0] FF_W    = FONT_WIDTH'(CH_FF);

    tc_state_e             state_q, state_d;
    logic [6:0]            x_q, x_d;
    logic [5:0]            y_q, y_d;
    logic [5:0]            y_nxt;
    logic                  wen_q, wen_d;
    logic [AW-1:0]         waddr_q, waddr_d;
    logic [FONT_WIDTH-1:0] wdata_q, wdata_d;
    logic                  busy_q;

    logic       sw_start;
    logic       sw_row_mode;
    logic [5:0] sw_row;
    logic [6:0] sw_x;
    logic [5:0] sw_y;
    logic       sw_done;

    // Same y*STRIDE + x form as the read path, evaluated at AW bits.
    function automatic logic [AW-1:0] cell_addr(input logic [6:0] x,
                                                input logic [5:0] y);
        return AW'(y) * AW'(STRIDE) + AW'(x);
    endfunction

    tile_sweep #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_sweep (
        .clk       (clk),
        .rst       (rst),
        .start_i   (sw_start),
        .row_mode_i(sw_row_mode),
        .row_i     (sw_row),
        .x_o       (sw_x),
        .y_o       (sw_y),
        .done_o    (sw_done)
    );

    assign y_nxt = (y_q == 6'(ROWS - 1)) ? 6'd0 : y_q + 6'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TC_CLR_SCR;
            x_q     <= '0;
            y_q     <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= (state_d != TC_IDLE);
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        wen_d       = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        sw_start    = 1'b0;
        sw_row_mode = 1'b0;
        sw_row      = y_nxt;
        unique case (state_q)
            TC_IDLE: begin
                if (valid_i) begin
                    unique case (1'b1)
                        (char_i >= BLANK_W): begin
                            wen_d   = 1'b1;
                            waddr_d = cell_addr(x_q, y_q);
                            wdata_d = char_i;
                            if (x_q == 7'(COLS - 1)) begin
                                x_d         = '0;
                                y_d         = y_nxt;
                                state_d     = TC_CLR_ROW;
                                sw_start    = 1'b1;
                                sw_row_mode = 1'b1;
                            end else begin
                                x_d = x_q + 7'd1;
                            end
                        end
                        (char_i == LF_W): begin
                            x_d         = '0;
                            y_d         = y_nxt;
                            state_d     = TC_CLR_ROW;
                            sw_start    = 1'b1;
                            sw_row_mode = 1'b1;
                        end
                        (char_i == CR_W): begin
                            x_d = '0;
                        end
                        (char_i == BS_W): begin
                            if (x_q != 7'd0) begin
                                x_d     = x_q - 7'd1;
                                wen_d   = 1'b1;
                                waddr_d = cell_addr(x_q - 7'd1, y_q);
                                wdata_d = BLANK_W;
                            end
                        end
                        (char_i == FF_W): begin
                            state_d  = TC_CLR_SCR;
                            sw_start = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            TC_CLR_SCR, TC_CLR_ROW: begin
                wen_d   = 1'b1;
                waddr_d = cell_addr(sw_x, sw_y);
                wdata_d = BLANK_W;
                if (sw_done) begin
                    state_d = TC_IDLE;
                    if (state_q == TC_CLR_SCR) begin
                        x_d = '0;
                        y_d = '0;
                    end
                end
            end
            default: begin
                state_d  = TC_CLR_SCR;
                sw_start = 1'b1;
            end
        endcase
    end

    assign ready_o = (state_q == TC_IDLE);
    assign wen_o   = wen_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign cur_x_o = x_q;
    assign cur_y_o = y_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_tile_console.sv
// Scoreboard bench for tile_console: a text-screen model predicts every RAM
// write; a monitor pops and compares whenever wen_o is seen.
module tb_tile_console;

    localparam int COLS = 80;
    localparam int ROWS = 60;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  char_i;
    logic        valid_i;
    logic        ready_o;
    logic        wen_o;
    logic [12:0] waddr_o;
    logic [7:0]  wdata_o;
    logic [6:0]  cur_x_o;
    logic [5:0]  cur_y_o;
    logic        busy_o;

    typedef struct {
        int addr;
        int data;
        bit mid;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  checks = 0;
    int  errors = 0;
    int  mx = 0;
    int  my = 0;
    int  cyc = 0;
    int  last_wr = 0;
    int  prev_wr = 0;

    tile_console dut (
        .clk    (clk),
        .rst    (rst),
        .char_i (char_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .wen_o  (wen_o),
        .waddr_o(waddr_o),
        .wdata_o(wdata_o),
        .cur_x_o(cur_x_o),
        .cur_y_o(cur_y_o),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        if (wen_o === 1'b1) begin
            prev_wr = last_wr;
            last_wr = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected addr=%0d data=%h required no write",
                         waddr_o, wdata_o);
            end else begin
                e = exp_q.pop_front();
                if (waddr_o !== 13'(e.addr) || wdata_o !== 8'(e.data)) begin
                    errors++;
                    $display("FAIL wr addr=%0d data=%h required addr=%0d data=%h",
                             waddr_o, wdata_o, e.addr, e.data);
                end
                if (e.mid) begin
                    checks++;
                    if (ready_o !== 1'b0 || busy_o !== 1'b1) begin
                        errors++;
                        $display("FAIL sweep_hs ready=%b busy=%b required ready=0 busy=1",
                                 ready_o, busy_o);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push_wr(input int a, input int d, input bit m);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.mid  = m;
        exp_q.push_back(w);
    endtask

    task automatic push_row(input int r);
        for (int i = 0; i < COLS; i++)
            push_wr(r * 80 + i, 32, i != COLS - 1);
    endtask

    task automatic push_screen();
        for (int i = 0; i < COLS * ROWS; i++)
            push_wr(i, 32, i != COLS * ROWS - 1);
    endtask

    // Screen model: what the text terminal should do for one accepted byte.
    task automatic model(input int ch);
        if (ch >= 32) begin
            push_wr(my * 80 + mx, ch, 1'b0);
            mx++;
            if (mx == COLS) begin
                mx = 0;
                my = (my + 1) % ROWS;
                push_row(my);
            end
        end else if (ch == 10) begin
            mx = 0;
            my = (my + 1) % ROWS;
            push_row(my);
        end else if (ch == 13) begin
            mx = 0;
        end else if (ch == 8) begin
            if (mx > 0) begin
                mx--;
                push_wr(my * 80 + mx, 32, 1'b0);
            end
        end else if (ch == 12) begin
            push_screen();
            mx = 0;
            my = 0;
        end
    endtask

    task automatic send(input int ch);
        int n;
        n = 0;
        @(negedge clk);
        while (ready_o !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            chk("send_timeout", n, 0);
        end else begin
            valid_i = 1'b1;
            char_i  = 8'(ch);
            @(posedge clk);
            model(ch);
            #1 valid_i = 1'b0;
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ready_o !== 1'b1) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", (n >= limit) ? 1 : 0, 0);
        chk("cur_x", int'(cur_x_o), mx);
        chk("cur_y", int'(cur_y_o), my);
        chk("busy_idle", int'(busy_o), 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_wen", int'(wen_o), 0);
        chk("rst_waddr", int'(waddr_o), 0);
        chk("rst_wdata", int'(wdata_o), 0);
        chk("rst_cur_x", int'(cur_x_o), 0);
        chk("rst_cur_y", int'(cur_y_o), 0);
        chk("rst_ready", int'(ready_o), 0);
        chk("rst_busy", int'(busy_o), 1);
    endtask

    initial begin
        int r;
        rst     = 1'b1;
        valid_i = 1'b0;
        char_i  = 8'h00;
        #1;
        chk_reset_vals();
        push_screen();
        mx = 0;
        my = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_idle(6000);

        send(65);
        send(66);
        wait_idle(100);
        chk("ab_gap", last_wr - prev_wr, 1);

        send(13);
        for (int i = 0; i < COLS; i++)
            send(65 + (i % 26));
        wait_idle(500);

        for (int i = 0; i < ROWS - 2; i++)
            send(10);
        wait_idle(500);
        send(10);
        wait_idle(500);

        send(88);
        send(8);
        send(8);
        wait_idle(100);

        send(72);
        send(73);
        send(12);
        wait_idle(6000);

        send(10);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals();
        exp_q.delete();
        push_screen();
        mx = 0;
        my = 0;
        @(negedge clk);
        rst = 1'b0;
        wait_idle(6000);

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 149));
            if (r == 0)
                send(12);
            else if (r < 100)
                send(int'($urandom_range(32, 126)));
            else if (r < 112)
                send(10);
            else if (r < 122)
                send(13);
            else if (r < 140)
                send(8);
            else if (r < 145)
                send(1);
            else
                send(27);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle(20000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
